// File: rtl/spi_master_param.sv
// spi_master_param
//   Parametrised SPI master exposed as a single 16-bit special-function register.
//   A write either releases chip select or asserts it and shifts one word out/in.
//   The configurable SCK divider, SPI mode and word width let one block serve several
//   peripherals. A hardware inter-word gap keeps the block busy so that the device
//   gets its recovery time without software having to wait for it.
//
// Parameters
//   WIDTH  bits per transfer (1..8)
//   DIV    clk cycles per SCK half-period (>= 2)
//   CPOL   SCK idle level
//   CPHA   0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//   GAP    clk cycles of enforced idle after the last bit (0 = none)
//
// Ports
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   load   SFR write strobe
//   in     write data: in[8]=1 releases CSX; in[8]=0 asserts CSX and sends in[WIDTH-1:0]
//   out    {busy, 7'd0, rx}; rx is zero-extended to 8 bits and valid while busy=0
//   SDO    MOSI, MSB first
//   SDI    MISO
//   SCK    serial clock
//   CSX    chip select, active low

module spi_master_param #(
    parameter int WIDTH = 8,
    parameter int DIV   = 16,
    parameter int CPOL  = 1,
    parameter int CPHA  = 0,
    parameter int GAP   = 1250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        SDO,
    input  logic        SDI,
    output logic        SCK,
    output logic        CSX
);

    localparam int   HW       = (DIV > 1)   ? $clog2(DIV)     : 1;
    localparam int   BW       = (WIDTH > 1) ? $clog2(WIDTH)   : 1;
    localparam int   GW       = (GAP > 0)   ? $clog2(GAP + 1) : 1;
    localparam logic SCK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [HW-1:0]    half_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             phase;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_next;
    logic             half_end;
    logic             last_bit;
    logic [7:0]       rx8;
    logic             unused_in;

    assign half_end = (half_cnt == HW'(DIV - 1));
    assign last_bit = (bit_cnt == BW'(WIDTH - 1));
    assign tx_next  = tx_sh << 1;
    // The cast drops the oldest bit, so this also works for WIDTH=1.
    assign rx_next  = WIDTH'({rx_sh, SDI});

    // Only in[8] and in[WIDTH-1:0] carry meaning. The remaining bits are reduced here
    // so that they are visibly consumed.
    assign unused_in = ^in;

    always_comb begin
        rx8 = '0;
        rx8[WIDTH-1:0] = rx_reg;
    end

    assign out = {(state != ST_IDLE), 7'd0, rx8};

    // Each bit is two half-periods. phase=0 is the first half (SCK at its idle level)
    // and phase=1 is the second half. The phase flips whenever half_cnt reaches DIV-1.
    // Whether a half-period boundary samples SDI or moves SDO depends on CPHA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            half_cnt <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            phase    <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_reg   <= '0;
            SCK      <= SCK_IDLE;
            SDO      <= 1'b0;
            CSX      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        if (in[8]) begin
                            CSX <= 1'b1;
                        end else begin
                            CSX      <= 1'b0;
                            tx_sh    <= in[WIDTH-1:0];
                            rx_sh    <= '0;
                            half_cnt <= '0;
                            bit_cnt  <= '0;
                            phase    <= 1'b0;
                            SCK      <= SCK_IDLE;
                            // With CPHA=0 the MSB has to be on the line before the first
                            // (leading) edge. With CPHA=1 it only appears on that edge.
                            SDO      <= (CPHA == 0) ? in[WIDTH-1] : 1'b0;
                            state    <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        phase    <= ~phase;
                        if (!phase) begin
                            // Leading edge.
                            SCK <= ~SCK_IDLE;
                            if (CPHA == 0) begin
                                rx_sh <= rx_next;
                            end else begin
                                SDO   <= tx_sh[WIDTH-1];
                                tx_sh <= tx_next;
                            end
                        end else begin
                            // Trailing edge, which is also the end of the bit.
                            SCK <= SCK_IDLE;
                            if (CPHA == 0) begin
                                tx_sh <= tx_next;
                                SDO   <= tx_next[WIDTH-1];
                            end else begin
                                rx_sh <= rx_next;
                            end
                            if (last_bit) begin
                                // With CPHA=1 the final bit is sampled on this same edge.
                                rx_reg  <= (CPHA == 0) ? rx_sh : rx_next;
                                SDO     <= 1'b0;
                                bit_cnt <= '0;
                                gap_cnt <= '0;
                                state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    // CSX stays low here. Only an explicit release write raises it.
                    if (gap_cnt == GW'(GAP - 1)) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param
//   Directed bench for spi_master_param. It builds several instances:
//     u_dut      WIDTH=8 DIV=2 CPOL=1 CPHA=0 GAP=4, driven by a small slave model
//     g_mode[g]  all four CPOL/CPHA combinations, SDO looped back to SDI
//     u_w5       WIDTH=5 DIV=3 CPOL=1 CPHA=0 GAP=4, looped back

module tb_spi_master_param;

    logic        clk;
    logic        rst_n;

    logic        load0;
    logic [15:0] in0;
    logic [15:0] out0;
    logic        sdo0;
    logic        sdi0;
    logic        sck0;
    logic        csx0;

    logic        load2;
    logic [15:0] in2;
    logic [15:0] out_m [4];
    logic [3:0]  sdo_m;
    logic [3:0]  sck_m;
    logic [3:0]  csx_m;

    logic        load5;
    logic [15:0] in5;
    logic [15:0] out5;
    logic        sdo5;
    logic        sck5;
    logic        csx5;

    int checks;
    int failures;

    // Slave model for u_dut. In mode CPOL=1/CPHA=0 the slave presents a bit before
    // each leading (falling) edge and moves to the next bit on the trailing (rising)
    // edge. It captures MOSI on the leading edge.
    logic [7:0] slave_word;
    logic [7:0] mosi;
    logic       sck0_q;
    int         scnt;
    logic       sck5_q;
    int         pulses5;

    initial begin
        sck0_q  = 1'b1;
        scnt    = 0;
        mosi    = 8'h00;
        sck5_q  = 1'b1;
        pulses5 = 0;
    end

    assign sdi0 = (scnt < 8) ? slave_word[3'(7 - scnt)] : 1'b0;

    always @(posedge clk) begin
        sck0_q <= sck0;
        if (load0 && !out0[15] && !in0[8]) scnt <= 0;
        else if (sck0 && !sck0_q && !csx0) scnt <= scnt + 1;
        if (!sck0 && sck0_q && !csx0) mosi <= {mosi[6:0], sdo0};
    end

    always @(posedge clk) begin
        sck5_q <= sck5;
        if (load5 && !out5[15]) pulses5 <= 0;
        else if (!sck5 && sck5_q) pulses5 <= pulses5 + 1;
    end

    spi_master_param #(
        .WIDTH(8), .DIV(2), .CPOL(1), .CPHA(0), .GAP(4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load0),
        .in   (in0),
        .out  (out0),
        .SDO  (sdo0),
        .SDI  (sdi0),
        .SCK  (sck0),
        .CSX  (csx0)
    );

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_master_param #(
            .WIDTH(8), .DIV(2), .CPOL(g / 2), .CPHA(g % 2), .GAP(4)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .load (load2),
            .in   (in2),
            .out  (out_m[g]),
            .SDO  (sdo_m[g]),
            .SDI  (sdo_m[g]),
            .SCK  (sck_m[g]),
            .CSX  (csx_m[g])
        );
    end

    spi_master_param #(
        .WIDTH(5), .DIV(3), .CPOL(1), .CPHA(0), .GAP(4)
    ) u_w5 (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load5),
        .in   (in5),
        .out  (out5),
        .SDO  (sdo5),
        .SDI  (sdo5),
        .SCK  (sck5),
        .CSX  (csx5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (out0 !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_out: got %h expected %h", out0, 16'h0000);
        end
        checks++;
        if (csx0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_csx: got %b expected %b", csx0, 1'b1);
        end
        checks++;
        if (sck0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_sck: got %b expected %b", sck0, 1'b1);
        end
        checks++;
        if (sdo0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_sdo: got %b expected %b", sdo0, 1'b0);
        end
        checks++;
        if (sck_m !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL reset_sck_modes: got %b expected %b", sck_m, 4'b1100);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_transfer0(input logic [15:0] word, input logic [7:0] slave,
                                 output int cyc);
        slave_word = slave;
        in0   = word;
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        cyc   = 0;
        while (out0[15] === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_basic_transfer();
        int cyc;
        run_transfer0(16'h00A5, 8'h3C, cyc);
        checks++;
        if (cyc != 36) begin
            failures++;
            $display("[TB] FAIL t1_busy_cycles: got %0d expected %0d", cyc, 36);
        end
        checks++;
        if (out0 !== 16'h003C) begin
            failures++;
            $display("[TB] FAIL t1_out: got %h expected %h", out0, 16'h003C);
        end
        checks++;
        if (mosi !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL t1_mosi: got %h expected %h", mosi, 8'hA5);
        end
        checks++;
        if (csx0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL t1_csx: got %b expected %b", csx0, 1'b0);
        end
        checks++;
        if (sck0 !== 1'b1 || sdo0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL t1_idle_lines: got sck=%b sdo=%b expected sck=1 sdo=0",
                     sck0, sdo0);
        end
    endtask

    task automatic test_csx_release();
        int sck_moves;
        int busy_seen;
        in0   = 16'h0100;
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        checks++;
        if (csx0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t4_csx: got %b expected %b", csx0, 1'b1);
        end
        checks++;
        if (out0 !== 16'h003C) begin
            failures++;
            $display("[TB] FAIL t4_out: got %h expected %h", out0, 16'h003C);
        end
        sck_moves = 0;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (sck0 !== 1'b1) sck_moves++;
            if (out0[15] !== 1'b0) busy_seen++;
            tick();
        end
        checks++;
        if (sck_moves != 0) begin
            failures++;
            $display("[TB] FAIL t4_sck_quiet: got %0d non-idle cycles expected 0", sck_moves);
        end
        checks++;
        if (busy_seen != 0) begin
            failures++;
            $display("[TB] FAIL t4_busy: got %0d busy cycles expected 0", busy_seen);
        end
    endtask

    task automatic test_modes();
        int   cyc;
        logic exp_sdo;
        logic exp_sck;
        in2   = 16'h0069;
        load2 = 1'b1;
        tick();
        load2 = 1'b0;
        cyc   = 0;
        while (out_m[0][15] === 1'b1 && cyc < 200) begin
            if (cyc == 4 || cyc == 6) begin
                for (int i = 0; i < 4; i++) begin
                    // 0x69: bit0=0, bit1=1. CPHA=1 shows bit1 only from mid-bit.
                    exp_sdo = (cyc == 6) ? 1'b1 : ((i % 2) == 0);
                    exp_sck = (cyc == 4) ? (i >= 2) : (i < 2);
                    checks++;
                    if (sdo_m[i] !== exp_sdo || sck_m[i] !== exp_sck) begin
                        failures++;
                        $display("[TB] FAIL t2_edge_mode%0d_cyc%0d: got sdo=%b sck=%b expected sdo=%b sck=%b",
                                 i, cyc, sdo_m[i], sck_m[i], exp_sdo, exp_sck);
                    end
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 36) begin
            failures++;
            $display("[TB] FAIL t2_busy_cycles: got %0d expected %0d", cyc, 36);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_m[i] !== 16'h0069) begin
                failures++;
                $display("[TB] FAIL t2_out_mode%0d: got %h expected %h", i, out_m[i], 16'h0069);
            end
            checks++;
            if (sck_m[i] !== (i >= 2) || csx_m[i] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL t2_idle_mode%0d: got sck=%b csx=%b expected sck=%b csx=0",
                         i, sck_m[i], csx_m[i], (i >= 2));
            end
        end
    endtask

    task automatic test_width5();
        int cyc;
        in5   = 16'h0013;
        load5 = 1'b1;
        tick();
        load5 = 1'b0;
        cyc   = 0;
        while (out5[15] === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 34) begin
            failures++;
            $display("[TB] FAIL t3_busy_cycles: got %0d expected %0d", cyc, 34);
        end
        checks++;
        if (pulses5 != 5) begin
            failures++;
            $display("[TB] FAIL t3_sck_pulses: got %0d expected %0d", pulses5, 5);
        end
        checks++;
        if (out5 !== 16'h0013) begin
            failures++;
            $display("[TB] FAIL t3_out: got %h expected %h", out5, 16'h0013);
        end
        checks++;
        if (csx5 !== 1'b0 || sck5 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t3_idle_lines: got csx=%b sck=%b expected csx=0 sck=1", csx5, sck5);
        end
    endtask

    task automatic test_load_while_busy();
        int cyc;
        slave_word = 8'hC3;
        in0   = 16'h005A;
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        cyc   = 0;
        while (out0[15] === 1'b1 && cyc < 200) begin
            // cyc 10 lands in the shift phase and cyc 33 lands in the gap.
            load0 = (cyc == 10 || cyc == 33);
            in0   = (cyc == 10 || cyc == 33) ? 16'h00FF : 16'h005A;
            tick();
            cyc++;
        end
        load0 = 1'b0;
        checks++;
        if (cyc != 36) begin
            failures++;
            $display("[TB] FAIL t5_busy_cycles: got %0d expected %0d", cyc, 36);
        end
        checks++;
        if (out0 !== 16'h00C3) begin
            failures++;
            $display("[TB] FAIL t5_out: got %h expected %h", out0, 16'h00C3);
        end
        checks++;
        if (mosi !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL t5_mosi: got %h expected %h", mosi, 8'h5A);
        end
        repeat (3) tick();
        checks++;
        if (out0[15] !== 1'b0 || csx0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL t5_no_restart: got busy=%b csx=%b expected busy=0 csx=0",
                     out0[15], csx0);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int cyc;
        slave_word = 8'h3C;
        in0   = 16'h00A5;
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        repeat (14) tick();
        // Second half of bit 3: SCK is away from its idle level.
        checks++;
        if (sck0 !== 1'b0 || out0[15] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t6_pre_reset: got sck=%b busy=%b expected sck=0 busy=1",
                     sck0, out0[15]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (csx0 !== 1'b1 || sck0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL t6_reset_lines: got csx=%b sck=%b expected csx=1 sck=1", csx0, sck0);
        end
        checks++;
        if (out0 !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL t6_reset_out: got %h expected %h", out0, 16'h0000);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_transfer0(16'h0081, 8'h7E, cyc);
        checks++;
        if (cyc != 36) begin
            failures++;
            $display("[TB] FAIL t6_busy_cycles: got %0d expected %0d", cyc, 36);
        end
        checks++;
        if (out0 !== 16'h007E) begin
            failures++;
            $display("[TB] FAIL t6_out: got %h expected %h", out0, 16'h007E);
        end
        checks++;
        if (mosi !== 8'h81) begin
            failures++;
            $display("[TB] FAIL t6_mosi: got %h expected %h", mosi, 8'h81);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        load0      = 1'b0;
        load2      = 1'b0;
        load5      = 1'b0;
        in0        = 16'h0000;
        in2        = 16'h0000;
        in5        = 16'h0000;
        slave_word = 8'h00;

        test_reset();
        test_basic_transfer();
        test_csx_release();
        test_modes();
        test_width5();
        test_load_while_busy();
        test_reset_mid_transfer();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
